// File: rtl/simd_logic_pkg.sv
// rtl/simd_logic_pkg.sv - op codes, element-width codes and helpers for the SIMD logic pipe
`ifndef SIMD_DATA_WIDTH
`define SIMD_DATA_WIDTH 64
`endif

package simd_logic_pkg;

  localparam logic [3:0] LOGIC_AND    = 4'd0;
  localparam logic [3:0] LOGIC_OR     = 4'd1;
  localparam logic [3:0] LOGIC_XOR    = 4'd2;
  localparam logic [3:0] LOGIC_ANDN   = 4'd3;
  localparam logic [3:0] LOGIC_ORN    = 4'd4;
  localparam logic [3:0] LOGIC_XNOR   = 4'd5;
  localparam logic [3:0] LOGIC_NOT    = 4'd6;
  localparam logic [3:0] LOGIC_PASS   = 4'd7;
  localparam logic [3:0] LOGIC_REDAND = 4'd8;
  localparam logic [3:0] LOGIC_REDOR  = 4'd9;

  localparam logic [1:0] EW_8  = 2'b00;
  localparam logic [1:0] EW_16 = 2'b01;
  localparam logic [1:0] EW_32 = 2'b10;
  localparam logic [1:0] EW_64 = 2'b11;

  function automatic logic is_reserved_op(input logic [3:0] op);
    return op > LOGIC_REDOR;
  endfunction

endpackage

// File: rtl/simd_logic_core.sv
// rtl/simd_logic_core.sv - combinational SIMD logic op with per-element reductions and byte-mask merge
module simd_logic_core
  import simd_logic_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [3:0]              op,
  input  logic [1:0]              ew,
  input  logic [DATA_WIDTH-1:0]   s1,
  input  logic [DATA_WIDTH-1:0]   s2,
  input  logic [DATA_WIDTH-1:0]   old,
  input  logic [DATA_WIDTH/8-1:0] mask,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    illegal
);

  logic                  red_and;
  logic [DATA_WIDTH-1:0] red;
  logic [DATA_WIDTH-1:0] comp;

  assign red_and = (op == LOGIC_REDAND);

  // Reduction flag lands in bit 0 of each element, upper bits zero
  always_comb begin
    red = '0;
    case (ew)
      EW_8:
        for (int i = 0; i < DATA_WIDTH/8; i++)
          red[i*8 +: 8] = {7'd0, red_and ? &s1[i*8 +: 8] : |s1[i*8 +: 8]};
      EW_16:
        for (int i = 0; i < DATA_WIDTH/16; i++)
          red[i*16 +: 16] = {15'd0, red_and ? &s1[i*16 +: 16] : |s1[i*16 +: 16]};
      EW_32:
        for (int i = 0; i < DATA_WIDTH/32; i++)
          red[i*32 +: 32] = {31'd0, red_and ? &s1[i*32 +: 32] : |s1[i*32 +: 32]};
      default:
        for (int i = 0; i < DATA_WIDTH/64; i++)
          red[i*64 +: 64] = {63'd0, red_and ? &s1[i*64 +: 64] : |s1[i*64 +: 64]};
    endcase
  end

  always_comb begin
    comp = '0;
    case (op)
      LOGIC_AND:    comp = s1 & s2;
      LOGIC_OR:     comp = s1 | s2;
      LOGIC_XOR:    comp = s1 ^ s2;
      LOGIC_ANDN:   comp = s1 & ~s2;
      LOGIC_ORN:    comp = s1 | ~s2;
      LOGIC_XNOR:   comp = ~(s1 ^ s2);
      LOGIC_NOT:    comp = ~s1;
      LOGIC_PASS:   comp = s1;
      LOGIC_REDAND: comp = red;
      LOGIC_REDOR:  comp = red;
      default:      comp = '0;
    endcase
  end

  always_comb begin
    result = old;
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (mask[b]) result[b*8 +: 8] = comp[b*8 +: 8];
  end

  assign illegal = is_reserved_op(op);

endmodule

// File: rtl/simd_logic_pipe.sv
// rtl/simd_logic_pipe.sv - 2-stage valid/ready SIMD logic pipe with tag passthrough and flush
module simd_logic_pipe
  import simd_logic_pkg::*;
#(
  parameter int DATA_WIDTH = `SIMD_DATA_WIDTH,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_op,
  input  logic [1:0]              in_ew,
  input  logic [DATA_WIDTH-1:0]   in_s1,
  input  logic [DATA_WIDTH-1:0]   in_s2,
  input  logic [DATA_WIDTH-1:0]   in_old,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_illegal
);

  logic                    v1, v2;
  logic                    s1_load, s2_load;
  logic [3:0]              r_op;
  logic [1:0]              r_ew;
  logic [DATA_WIDTH-1:0]   r_s1, r_s2, r_old;
  logic [DATA_WIDTH/8-1:0] r_mask;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic [DATA_WIDTH-1:0]   core_result;
  logic                    core_illegal;

  // No skid buffer: in_ready follows out_ready combinationally
  assign s2_load   = !v2 || out_ready;
  assign s1_load   = !v1 || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (s1_load) v1 <= in_valid;
      if (s2_load) v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      r_op   <= in_op;
      r_ew   <= in_ew;
      r_s1   <= in_s1;
      r_s2   <= in_s2;
      r_old  <= in_old;
      r_mask <= in_mask;
      r_tag  <= in_tag;
    end
  end

  simd_logic_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .op      (r_op),
    .ew      (r_ew),
    .s1      (r_s1),
    .s2      (r_s2),
    .old     (r_old),
    .mask    (r_mask),
    .result  (core_result),
    .illegal (core_illegal)
  );

  // Output registers only move on a real handoff, so a stalled result stays put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (s2_load && v1) begin
      out_result  <= core_result;
      out_tag     <= r_tag;
      out_illegal <= core_illegal;
    end
  end

endmodule

// File: tb/tb_simd_logic_pipe.sv
// tb/tb_simd_logic_pipe.sv - directed self-checking bench for simd_logic_pipe
module tb_simd_logic_pipe;

  localparam int DW = 64;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [3:0]    in_op;
  logic [1:0]    in_ew;
  logic [DW-1:0] in_s1, in_s2, in_old, out_result;
  logic [7:0]    in_mask;
  logic [TW-1:0] in_tag, out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simd_logic_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_ew(in_ew),
    .in_s1(in_s1), .in_s2(in_s2), .in_old(in_old), .in_mask(in_mask), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] ew, input logic [63:0] s1,
                       input logic [63:0] s2, input logic [63:0] old, input logic [7:0] mask,
                       input logic [4:0] tag);
    in_valid = 1'b1; in_op = op; in_ew = ew; in_s1 = s1; in_s2 = s2;
    in_old = old; in_mask = mask; in_tag = tag;
  endtask

  // Issue one op with out_ready=1 and check it surfaces exactly two edges later
  task automatic run_one(input string name, input logic [3:0] op, input logic [1:0] ew,
                         input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] old,
                         input logic [7:0] mask, input logic [4:0] tag,
                         input logic [63:0] exp, input logic exp_ill);
    drive(op, ew, s1, s2, old, mask, tag);
    tick();
    in_valid = 1'b0;
    check({name, "_lat1_valid"}, {63'd0, out_valid}, 64'd0);
    tick();
    check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({name, "_result"}, out_result, exp);
    check({name, "_tag"}, {59'd0, out_tag}, {59'd0, tag});
    check({name, "_illegal"}, {63'd0, out_illegal}, {63'd0, exp_ill});
  endtask

  localparam logic [63:0] A = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [63:0] B = 64'hFF00_FF00_FF00_FF00;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic [63:0] op_exp [8];
  logic        acc, outx, held;
  logic [63:0] held_res;
  logic [4:0]  held_tag;
  int          next_in, next_out;

  initial begin
    op_exp[0] = 64'hF000_F000_F000_F000;
    op_exp[1] = 64'hFFF0_FFF0_FFF0_FFF0;
    op_exp[2] = 64'h0FF0_0FF0_0FF0_0FF0;
    op_exp[3] = 64'h00F0_00F0_00F0_00F0;
    op_exp[4] = 64'hF0FF_F0FF_F0FF_F0FF;
    op_exp[5] = 64'hF00F_F00F_F00F_F00F;
    op_exp[6] = 64'h0F0F_0F0F_0F0F_0F0F;
    op_exp[7] = 64'hF0F0_F0F0_F0F0_F0F0;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_ew = '0; in_s1 = '0; in_s2 = '0; in_old = '0; in_mask = '0; in_tag = '0;
    repeat (3) tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_tag", {59'd0, out_tag}, 64'd0);
    check("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_idle_valid", {63'd0, out_valid}, 64'd0);

    run_one("and",    4'd0, 2'b00, A, B, 64'd0, 8'hFF, 5'd1, 64'hF000_F000_F000_F000, 1'b0);
    run_one("andn",   4'd3, 2'b00, A, B, 64'd0, 8'hFF, 5'd2, 64'h00F0_00F0_00F0_00F0, 1'b0);
    run_one("xnor",   4'd5, 2'b00, A, B, 64'd0, 8'hFF, 5'd3, 64'hF00F_F00F_F00F_F00F, 1'b0);
    run_one("redor16", 4'd9, 2'b01, 64'h0000_0001_FFFF_0000, 64'd0, 64'd0, 8'hFF, 5'd4,
            64'h0000_0001_0001_0000, 1'b0);
    run_one("redand8", 4'd8, 2'b00, 64'hFF7F_FFFF_0000_00FF, 64'd0, 64'd0, 8'hFF, 5'd5,
            64'h0100_0101_0000_0001, 1'b0);
    run_one("redand32", 4'd8, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0, 8'hFF, 5'd6,
            64'h0000_0001_0000_0000, 1'b0);
    run_one("redor64", 4'd9, 2'b11, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 8'hFF, 5'd7,
            64'h0000_0000_0000_0001, 1'b0);
    run_one("merge",  4'd1, 2'b00, 64'd0, 64'h1111_1111_1111_1111, 64'hAAAA_AAAA_AAAA_AAAA,
            8'h0F, 5'd8, 64'hAAAA_AAAA_1111_1111, 1'b0);
    run_one("ill12",  4'd12, 2'b00, ONES, ONES, 64'd0, 8'hFF, 5'd9, 64'd0, 1'b1);
    run_one("ill15m", 4'd15, 2'b00, ONES, ONES, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0, 5'd10,
            64'h0000_0000_AAAA_AAAA, 1'b1);

    // All eight logic ops back to back: one result per cycle
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(i[3:0], 2'b00, A, B, 64'd0, 8'hFF, i[4:0]);
      else in_valid = 1'b0;
      tick();
      if (i >= 1) begin
        check($sformatf("stream%0d_valid", i-1), {63'd0, out_valid}, 64'd1);
        check($sformatf("stream%0d_result", i-1), out_result, op_exp[i-1]);
        check($sformatf("stream%0d_tag", i-1), {59'd0, out_tag}, 64'(i-1));
      end
    end
    tick();
    check("stream_drain", {63'd0, out_valid}, 64'd0);

    // Backpressure: out_ready low for the first 4 cycles
    next_in = 0; next_out = 0;
    for (int cyc = 0; cyc < 40 && next_out < 6; cyc++) begin
      if (next_in < 6)
        drive(4'd7, 2'b00, {8{3'd0, next_in[4:0]}}, 64'd0, 64'd0, 8'hFF, next_in[4:0]);
      else
        in_valid = 1'b0;
      out_ready = (cyc >= 4);
      #1;
      acc  = in_valid && in_ready;
      outx = out_valid && out_ready;
      held = out_valid && !out_ready;
      held_res = out_result;
      held_tag = out_tag;
      if (cyc == 2) check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
      if (outx) begin
        check($sformatf("bp_tag%0d", next_out), {59'd0, out_tag}, 64'(next_out));
        check($sformatf("bp_res%0d", next_out), out_result, {8{3'd0, next_out[4:0]}});
        next_out++;
      end
      @(posedge clk);
      #1;
      if (acc) next_in++;
      if (held) begin
        check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold_result", out_result, held_res);
        check("bp_hold_tag", {59'd0, out_tag}, {59'd0, held_tag});
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_all_out", 64'(next_out), 64'd6);
    check("bp_all_in", 64'(next_in), 64'd6);
    tick();
    check("bp_no_dup", {63'd0, out_valid}, 64'd0);

    // Flush with two ops in flight plus an offered op that must be dropped
    drive(4'd7, 2'b00, 64'h1, 64'd0, 64'd0, 8'hFF, 5'd20);
    tick();
    drive(4'd7, 2'b00, 64'h2, 64'd0, 64'd0, 8'hFF, 5'd21);
    tick();
    drive(4'd7, 2'b00, 64'h3, 64'd0, 64'd0, 8'hFF, 5'd22);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid0", {63'd0, out_valid}, 64'd0);
    tick();
    check("flush_dropped", {63'd0, out_valid}, 64'd0);
    run_one("post_flush", 4'd2, 2'b00, A, B, 64'd0, 8'hFF, 5'd23, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0);

    // Asynchronous reset in the middle of a stream
    drive(4'd7, 2'b00, ONES, 64'd0, 64'd0, 8'hFF, 5'd24);
    tick();
    tick();
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_result", out_result, 64'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_logic_pipe.md
Name: simd_logic_pipe

Overview:
Parametrised, 2-stage pipelined SIMD logic unit for the execute stage; successor of the single-cycle combinational logic block. Adds an encoded op set (incl. ANDN/ORN/XNOR/NOT and per-element reductions), selectable element width, byte-mask merge with an old destination value, and valid/ready flow control with tag passthrough and flush. Sits between SIMD issue and the writeback arbiter.

Parameters:
DATA_WIDTH, `SIMD_DATA_WIDTH, vector width in bits; multiple of 64.
TAG_WIDTH, 5, width of the opaque tag carried alongside each operation.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous kill of all in-flight operations.
in_valid  input  1  operation offered.
in_ready  output  1  unit accepts the operation this cycle.
in_op  input  4  operation code, see Behaviour.
in_ew  input  2  element width: 00=8, 01=16, 10=32, 11=64 bits.
in_s1  input  DATA_WIDTH  source 1.
in_s2  input  DATA_WIDTH  source 2.
in_old  input  DATA_WIDTH  old destination value for masked bytes.
in_mask  input  DATA_WIDTH/8  byte enables; 1 = write result byte.
in_tag  input  TAG_WIDTH  opaque tag.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
out_result  output  DATA_WIDTH  merged result.
out_tag  output  TAG_WIDTH  tag of the result.
out_illegal  output  1  op code was reserved.

Behaviour:
- Op codes: 0 AND, 1 OR, 2 XOR, 3 ANDN (s1 & ~s2), 4 ORN (s1 | ~s2), 5 XNOR, 6 NOT s1, 7 PASS s1.
- Op 8 REDAND: per element, result element = 1 if the s1 element is all ones, else 0. Value is zero-extended to the element width.
- Op 9 REDOR: per element, result element = 1 if the s1 element is non-zero, else 0.
- Ops 10–15 are reserved: result 0 before masking, out_illegal = 1.
- in_ew affects only ops 8/9.
- Merge: out byte i = in_mask[i] ? computed byte i : in_old byte i. The merge applies to every op, including reserved ones.
- Stage S1: capture operands, then compute the op and merge combinationally into the S1→S2 register. Stage S2 is the output register.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+2, given no stall.
- Throughput: one op per cycle.
- Per-stage valid bits v1, v2.
- Stage advance:
  - S2 loads when !v2 || out_ready.
  - S1 loads when !v1 || S2 loads.
  - in_ready = !v1 || S2 loads. in_ready is combinational from out_ready; there is no skid buffer.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - A stalled stage holds its data and tag unchanged.
- Simultaneous input and output transfer in a full pipe: both complete and the pipe stays full.
- flush:
  - Clears v1 and v2 at the edge.
  - Any input offered in the flush cycle is dropped. in_ready may be 1, but the op is discarded.
  - out_valid = 0 in the cycle after flush.
- Reset: v1 = v2 = 0. out_valid = 0, out_result = 0, out_tag = 0, out_illegal = 0. in_ready = 1 once rst_n is high.
- Reset mid-operation discards all in-flight ops.
- Data registers need no reset except the output registers listed above.
- out_result, out_tag and out_illegal are stable while out_valid && !out_ready.

Decomposition:
- Shared package/header: op code constants (LOGIC_AND ... LOGIC_REDOR), element-width codes, and the reserved-op range check.
- One natural sub-module: simd_logic_core. It is purely combinational: op, ew, s1, s2, old, mask → result, illegal.
- The top level holds only the pipeline registers and flow control.

Test Plan:
- DATA_WIDTH=64, mask all ones, s1=0xF0F0_F0F0_F0F0_F0F0, s2=0xFF00_FF00_FF00_FF00:
  - AND → 0xF000_F000_F000_F000; ANDN → 0x00F0_00F0_00F0_00F0; XNOR → 0xF00F_F00F_F00F_F00F.
  - Each result appears 2 cycles after acceptance.
- REDOR, ew=01, s1=0x0000_0001_FFFF_0000 → 0x0000_0001_0001_0000.
- REDAND, ew=00, s1=0xFF7F_FFFF_0000_00FF → 0x0100_0101_0000_0001.
- Mask merge:
  - Inputs: op OR, s1=0, s2=0x1111_1111_1111_1111, old=0xAAAA_AAAA_AAAA_AAAA, mask=0x0F.
  - Expected: 0xAAAA_AAAA_1111_1111.
- Backpressure:
  - Stimulus: stream 6 ops with tags 0–5, hold out_ready=0 for 4 cycles, then release.
  - Expected: in_ready drops after 2 accepts; no loss or duplication; tags come out 0–5 in order with correct results; held outputs are stable.
- Flush and illegal:
  - Flush with 2 ops in flight → no out_valid next cycle, and the next op issues normally.
  - op=12 with mask=0xFF → result 0, out_illegal=1.
  - rst_n asserted mid-stream → out_valid=0 immediately.
